test_sched: RTL

TEST_SCHED -- requirements
Module: test_sched

---
 rtl/test_sched.sv | 104 ++++++++++
 1 files changed

// File: rtl/test_sched.sv
// Sequences NUM_TESTS test instances: reset hold, run, then advance or stop.
// Define TEST_SCHED_TIMEOUT_EN to compile in the RUN-state watchdog.
module test_sched #(
  parameter int NUM_TESTS      = 4,
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [NUM_TESTS-1:0] test_reset,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic [3:0]           index,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [3:0]           fail_index
);

  localparam int CMAX = (TIMEOUT_CYCLES > RESET_CYCLES) ?
                        TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [NUM_TESTS-1:0] ALL  = '1;
  localparam logic [NUM_TESTS-1:0] ONE  = NUM_TESTS'(1);
  localparam logic [3:0]           LAST = 4'(NUM_TESTS - 1);
  localparam logic [CW-1:0]        HEND = CW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [15:0]   fail_w;
  logic [15:0]   fin_w;
  logic          fail_s;
  logic          fin_s;

  // Only the selected instance is observed; other bits are don't-care.
  assign fail_w = 16'(test_fail);
  assign fin_w  = 16'(test_finish);
  assign fail_s = fail_w[index];
  assign fin_s  = fin_w[index];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HOLD;
      count      <= '0;
      index      <= '0;
      test_reset <= ALL;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_index <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (count == HEND) begin
            state      <= RUN;
            count      <= '0;
            test_reset <= ~(ONE << index);
          end else begin
            count <= count + CW'(1);
          end
        end
        RUN: begin
          if (fail_s) begin
            state      <= DONE;
            test_reset <= ALL;
            done       <= 1'b1;
            pass       <= 1'b0;
            fail_index <= index;
          end else if (fin_s) begin
            test_reset <= ALL;
            count      <= '0;
            if (index == LAST) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= HOLD;
              index <= index + 4'd1;
            end
          end
`ifdef TEST_SCHED_TIMEOUT_EN
          else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
            state      <= DONE;
            test_reset <= ALL;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
            fail_index <= index;
          end else begin
            count <= count + CW'(1);
          end
`endif
        end
        DONE: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
